serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 88 ++++++++
 tb/tb_serial_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one result bit per clock, LSB first
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter value on the final RUN edge; the WIDTH-th edge moves to DONE.
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             sum_bit;
    logic             carry_next;

    // Full adder over the current operand LSBs and the stored carry.
    always_comb begin
        sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    end

    // FSM plus datapath: load on an accepted start, shift one bit per RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        a_sr    <= a;
                        b_sr    <= b;
                        carry   <= 1'b0;
                        bit_cnt <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                    end else begin
                        // sum/cout are left untouched so the result stays readable.
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    sum     <= {sum_bit, sum[WIDTH-1:1]};
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    carry   <= carry_next;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state <= DONE;
                        cout  <= carry_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags decode straight from state so reset clears them at once.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder (WIDTH=8)
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_vec;
    int n_err;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands with start on the current negedge; return at the
    // negedge after the accepting edge with operands scrambled.
    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = bv ^ 8'h5A;
    endtask

    // Called at the first negedge after acceptance; waits for done and checks it.
    task automatic finish_add(input string tag, input logic [7:0] es, input logic ec, input bit linger);
        int cyc;
        int busy_cyc;
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd8);
        check({tag, " busy_cycles"}, 32'(busy_cyc), 32'd8);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        if (linger) begin
            @(negedge clk);
            check({tag, " done_pulse_len"}, 32'(done), 32'd0);
            check({tag, " idle_busy"}, 32'(busy), 32'd0);
            check({tag, " sum_hold"}, 32'(sum), 32'(es));
            check({tag, " cout_hold"}, 32'(cout), 32'(ec));
        end
    endtask

    task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] es, input logic ec);
        @(negedge clk);
        launch(av, bv);
        finish_add(tag, es, ec, 1'b1);
    endtask

    initial begin
        int pulses;
        logic [7:0] seen_sum;
        logic seen_cout;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;

        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_add("zero", 8'h00, 8'h00, 8'h00, 1'b0);
        do_add("64+37", 8'h64, 8'h37, 8'h9B, 1'b0);
        do_add("C8+64", 8'hC8, 8'h64, 8'h2C, 1'b1);
        do_add("FF+01", 8'hFF, 8'h01, 8'h00, 1'b1);
        do_add("FF+FF", 8'hFF, 8'hFF, 8'hFE, 1'b1);

        // start while busy must be ignored
        @(negedge clk);
        launch(8'h10, 8'h20);
        repeat (2) @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        pulses    = 0;
        seen_sum  = 8'hXX;
        seen_cout = 1'bx;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                pulses++;
                seen_sum  = sum;
                seen_cout = cout;
            end
            @(negedge clk);
        end
        check("busy_start pulses", 32'(pulses), 32'd1);
        check("busy_start sum", 32'(seen_sum), 32'h30);
        check("busy_start cout", 32'(seen_cout), 32'd0);
        check("busy_start idle", 32'(busy), 32'd0);

        // reset in the 4th RUN cycle aborts
        launch(8'hC3, 8'h3C);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no_done", 32'(pulses), 32'd0);
        check("abort stays_idle", 32'(busy), 32'd0);

        // start on the first edge after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launch(8'h01, 8'h02);
        finish_add("post_rst", 8'h03, 1'b0, 1'b1);

        // back-to-back: start held through DONE
        @(negedge clk);
        launch(8'h12, 8'h34);
        finish_add("b2b_first", 8'h46, 1'b0, 1'b0);
        launch(8'h0F, 8'hF1);
        check("b2b restart busy", 32'(busy), 32'd1);
        finish_add("b2b_second", 8'h00, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
